dac_frame_unpacker: RTL and testbench



---
 rtl/dac_pkg.sv | 28 ++
 rtl/open_sync.sv | 29 ++
 rtl/dac_frame_unpacker.sv | 138 +++++++++++++
 tb/tb_dac_frame_unpacker.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants, types and helpers for the DAC frame unpacker.
//   FIFO_WIDTH    width of the Xillybus write-FIFO word
//   DAC_CHANNELS  default channel count, kept equal to adc_params::dac_channels
//   dac_state_e   fetch/full states of the frame buffer
//   pack_factor   samples carried per FIFO word
//   frame_words   FIFO words needed for one complete frame
package dac_pkg;

   localparam int unsigned FIFO_WIDTH   = 32;
   localparam int unsigned DAC_CHANNELS = 4;

   typedef enum logic [0:0] {
      FETCH,
      FULL
   } dac_state_e;

   function automatic int unsigned pack_factor(input int unsigned sample_width);
      return FIFO_WIDTH / sample_width;
   endfunction

   function automatic int unsigned frame_words(input int unsigned channels,
                                               input int unsigned sample_width);
      int unsigned pack;
      pack = pack_factor(sample_width);
      return (channels + pack - 1) / pack;
   endfunction

endpackage

// File: rtl/open_sync.sv
// Two-flop synchroniser for the pipe-open flag coming from the bus_clk domain.
// Shared with the ADC capture path.
//   clk       destination clock
//   reset     synchronous, active-high; forces sync_out low
//   async_in  flag from the foreign clock domain
//   sync_out  flag synchronised to clk
module open_sync (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic sync_out
);

   (* ASYNC_REG = "TRUE" *) logic meta_q;
   (* ASYNC_REG = "TRUE" *) logic sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
      end
   end

   assign sync_out = sync_q;

endmodule

// File: rtl/dac_frame_unpacker.sv
// Pulls packed multi-channel frames from a first-word-fall-through FIFO into a frame
// buffer and presents one complete frame per DAC request.
//   capture_clk       clock
//   reset             synchronous, active-high
//   dac_open_bus      pipe-open flag (bus_clk domain)
//   dac_open          synchronised pipe-open flag
//   dac_request       one-cycle request pulse from the enabled DAC
//   dac_buffer        current frame, channel c at [c*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   dac_buffer_ready  pulse: dac_buffer updated with a new frame
//   dac_underrun      pulse: a request found no complete frame
//   underrun_count    saturating underrun total since open
//   dac_rden          FIFO pop
//   dac_fifo_data     FIFO head word
//   dac_empty         FIFO empty
module dac_frame_unpacker
   import dac_pkg::*;
#(
   parameter int unsigned CHANNELS      = DAC_CHANNELS,
   parameter int unsigned SAMPLE_WIDTH  = 32,
   parameter int unsigned UNDERRUN_ZERO = 0,
   parameter int unsigned COUNT_WIDTH   = 16
) (
   input  logic                             capture_clk,
   input  logic                             reset,
   input  logic                             dac_open_bus,
   output logic                             dac_open,
   input  logic                             dac_request,
   output logic [CHANNELS*SAMPLE_WIDTH-1:0] dac_buffer,
   output logic                             dac_buffer_ready,
   output logic                             dac_underrun,
   output logic [COUNT_WIDTH-1:0]           underrun_count,
   output logic                             dac_rden,
   input  logic [FIFO_WIDTH-1:0]            dac_fifo_data,
   input  logic                             dac_empty
);

   localparam int unsigned WORDS = frame_words(CHANNELS, SAMPLE_WIDTH);
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int unsigned BUF_W = CHANNELS * SAMPLE_WIDTH;

   if (!(SAMPLE_WIDTH == 32 || SAMPLE_WIDTH == 16 || SAMPLE_WIDTH == 8)) begin : gen_bad_width
      $error("SAMPLE_WIDTH must be 32, 16 or 8");
   end

   dac_state_e                         state_q, state_d;
   logic [IDX_W-1:0]                   idx_q, idx_d;
   logic [WORDS-1:0][FIFO_WIDTH-1:0]   frame_q, frame_d;
   logic [WORDS*FIFO_WIDTH-1:0]        frame_flat;
   logic [BUF_W-1:0]                   buffer_q, buffer_d;
   logic                               ready_q, ready_d;
   logic                               underrun_q, underrun_d;
   logic [COUNT_WIDTH-1:0]             count_q, count_d;
   logic                               soft_reset;

   open_sync u_open_sync (
      .clk      (capture_clk),
      .reset    (reset),
      .async_in (dac_open_bus),
      .sync_out (dac_open)
   );

   // Closing the pipe also discards any partial frame, so channels re-align on reopen.
   assign soft_reset = reset | ~dac_open;

   // Sub-word samples are packed LSB-first and word 0 sits lowest, so the flattened
   // frame already has channel c at bit c*SAMPLE_WIDTH; unused top bits drop off.
   assign frame_flat = frame_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      frame_d    = frame_q;
      buffer_d   = buffer_q;
      ready_d    = 1'b0;
      underrun_d = 1'b0;
      count_d    = count_q;
      dac_rden   = 1'b0;

      unique case (state_q)
         FETCH: begin
            // Keep the FIFO intact while held in reset.
            dac_rden = ~dac_empty & ~soft_reset;
            // A request mid-fetch is an underrun; the fetch itself carries on.
            if (dac_request) begin
               underrun_d = 1'b1;
               if (count_q != '1) begin
                  count_d = count_q + 1'b1;
               end
               if (UNDERRUN_ZERO != 0) begin
                  buffer_d = '0;
               end
            end
            if (!dac_empty) begin
               frame_d[idx_q] = dac_fifo_data;
               if (idx_q == IDX_W'(WORDS - 1)) begin
                  state_d = FULL;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         FULL: begin
            if (dac_request) begin
               buffer_d = frame_flat[BUF_W-1:0];
               ready_d  = 1'b1;
               state_d  = FETCH;
            end
         end
      endcase
   end

   always_ff @(posedge capture_clk) begin
      if (soft_reset) begin
         state_q    <= FETCH;
         idx_q      <= '0;
         frame_q    <= '0;
         buffer_q   <= '0;
         ready_q    <= 1'b0;
         underrun_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         frame_q    <= frame_d;
         buffer_q   <= buffer_d;
         ready_q    <= ready_d;
         underrun_q <= underrun_d;
         count_q    <= count_d;
      end
   end

   assign dac_buffer       = buffer_q;
   assign dac_buffer_ready = ready_q;
   assign dac_underrun     = underrun_q;
   assign underrun_count   = count_q;

endmodule

// File: tb/tb_dac_frame_unpacker.sv
// Bench for dac_frame_unpacker: instance A uses default parameters, instance B uses
// CHANNELS=3, SAMPLE_WIDTH=16, UNDERRUN_ZERO=1, COUNT_WIDTH=2. Each has a FWFT FIFO model
// and a scoreboard of expected request outcomes.
module tb_dac_frame_unpacker;

   typedef struct {
      bit           under;
      logic [127:0] buf_v;
      int           cnt;
      int           cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   // Instance A
   logic         a_open_bus, a_open, a_req, a_ready, a_under, a_rden, a_empty;
   logic [127:0] a_buf;
   logic [15:0]  a_cnt;
   logic [31:0]  a_data;
   logic [31:0]  a_fifo[$];
   exp_t         a_sb[$];
   int           a_pops = 0;

   // Instance B
   logic         b_open_bus, b_open, b_req, b_ready, b_under, b_rden, b_empty;
   logic [47:0]  b_buf;
   logic [1:0]   b_cnt;
   logic [31:0]  b_data;
   logic [31:0]  b_fifo[$];
   exp_t         b_sb[$];
   int           b_pops = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dac_frame_unpacker u_dut_a (
      .capture_clk      (clk),
      .reset            (reset),
      .dac_open_bus     (a_open_bus),
      .dac_open         (a_open),
      .dac_request      (a_req),
      .dac_buffer       (a_buf),
      .dac_buffer_ready (a_ready),
      .dac_underrun     (a_under),
      .underrun_count   (a_cnt),
      .dac_rden         (a_rden),
      .dac_fifo_data    (a_data),
      .dac_empty        (a_empty)
   );

   dac_frame_unpacker #(
      .CHANNELS      (3),
      .SAMPLE_WIDTH  (16),
      .UNDERRUN_ZERO (1),
      .COUNT_WIDTH   (2)
   ) u_dut_b (
      .capture_clk      (clk),
      .reset            (reset),
      .dac_open_bus     (b_open_bus),
      .dac_open         (b_open),
      .dac_request      (b_req),
      .dac_buffer       (b_buf),
      .dac_buffer_ready (b_ready),
      .dac_underrun     (b_under),
      .underrun_count   (b_cnt),
      .dac_rden         (b_rden),
      .dac_fifo_data    (b_data),
      .dac_empty        (b_empty)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // FIFO models: pop on the clock edge, refresh the FWFT head on the falling edge.
   always @(posedge clk) begin
      if (a_rden) begin
         if (a_fifo.size() > 0) begin
            void'(a_fifo.pop_front());
            a_pops++;
         end else check_eq("a_pop_empty", 1, 0);
      end
      if (b_rden) begin
         if (b_fifo.size() > 0) begin
            void'(b_fifo.pop_front());
            b_pops++;
         end else check_eq("b_pop_empty", 1, 0);
      end
   end

   always @(negedge clk) begin
      a_empty = (a_fifo.size() == 0);
      a_data  = (a_fifo.size() > 0) ? a_fifo[0] : 32'h0;
      b_empty = (b_fifo.size() == 0);
      b_data  = (b_fifo.size() > 0) ? b_fifo[0] : 32'h0;
   end

   // Scoreboard monitors.
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (a_ready || a_under) begin
         if (a_sb.size() == 0) check_eq("a_spurious_pulse", {a_ready, a_under}, 0);
         else begin
            e = a_sb.pop_front();
            check_eq("a_underrun", a_under, e.under);
            check_eq("a_ready", a_ready, !e.under);
            check_eq("a_buffer", a_buf, e.buf_v);
            check_eq("a_count", a_cnt, e.cnt);
            check_eq("a_latency", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (b_ready || b_under) begin
         if (b_sb.size() == 0) check_eq("b_spurious_pulse", {b_ready, b_under}, 0);
         else begin
            e = b_sb.pop_front();
            check_eq("b_underrun", b_under, e.under);
            check_eq("b_ready", b_ready, !e.under);
            check_eq("b_buffer", b_buf, e.buf_v);
            check_eq("b_count", b_cnt, e.cnt);
            check_eq("b_latency", cyc, e.cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic req_a(input bit under, input logic [127:0] buf_v, input int cnt);
      exp_t e;
      e.under = under; e.buf_v = buf_v; e.cnt = cnt; e.cyc = cyc + 1;
      a_sb.push_back(e);
      a_req = 1'b1;
      tick(1);
      a_req = 1'b0;
   endtask

   task automatic req_b(input bit under, input logic [127:0] buf_v, input int cnt);
      exp_t e;
      e.under = under; e.buf_v = buf_v; e.cnt = cnt; e.cyc = cyc + 1;
      b_sb.push_back(e);
      b_req = 1'b1;
      tick(1);
      b_req = 1'b0;
   endtask

   // Bounded wait for every expected pulse to have been seen.
   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((a_sb.size() != 0 || b_sb.size() != 0) && n < 8) begin
         tick(1);
         n++;
      end
      check_eq(tag, a_sb.size() + b_sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; a_open_bus = 1'b0; b_open_bus = 1'b0; a_req = 1'b0; b_req = 1'b0;
      a_fifo.push_back(32'h11); a_fifo.push_back(32'h22);
      a_fifo.push_back(32'h33); a_fifo.push_back(32'h44);
      b_fifo.push_back(32'hBBBB_AAAA); b_fifo.push_back(32'h0000_CCCC);
      tick(3);
      check_eq("rst_a_buffer", a_buf, 0);
      check_eq("rst_a_count", a_cnt, 0);
      check_eq("rst_a_open", a_open, 0);
      check_eq("rst_a_rden", a_rden, 0);
      check_eq("rst_b_rden", b_rden, 0);
      check_eq("rst_pulses", {a_ready, a_under, b_ready, b_under}, 0);
      reset = 1'b0;
      tick(2);
      check_eq("closed_a_rden", a_rden, 0);
      a_open_bus = 1'b1; b_open_bus = 1'b1;
      tick(1);
      check_eq("open_sync_stage1", a_open, 0);
      tick(1);
      check_eq("open_sync_stage2", a_open, 1);
      tick(8);
      check_eq("a_prefetch_pops", a_pops, 4);
      check_eq("b_prefetch_pops", b_pops, 2);
      check_eq("a_full_rden", a_rden, 0);

      // Full frames delivered.
      req_a(1'b0, 128'h44_0000_0033_0000_0022_0000_0011 | 128'h0, 0);
      req_b(1'b0, 128'hCCCC_BBBB_AAAA, 0);
      drain("drain_first_frames");
      check_eq("a_pops_after_frame", a_pops, 4);
      check_eq("b_pops_after_frame", b_pops, 2);

      // Partial frame: underrun, then aligned delivery.
      a_fifo.push_back(32'h55); a_fifo.push_back(32'h66);
      b_fifo.push_back(32'h2222_1111);
      tick(6);
      req_a(1'b1, 128'h0000_0044_0000_0033_0000_0022_0000_0011, 1);
      req_b(1'b1, 128'h0, 1);
      drain("drain_underrun");
      a_fifo.push_back(32'h77); a_fifo.push_back(32'h88);
      b_fifo.push_back(32'h0000_3333);
      tick(6);
      check_eq("a_pops_second", a_pops, 8);
      req_a(1'b0, 128'h0000_0088_0000_0077_0000_0066_0000_0055, 1);
      req_b(1'b0, 128'h3333_2222_1111, 1);
      drain("drain_aligned");

      // Saturation: five back-to-back underruns on a 2-bit counter.
      for (int i = 0; i < 5; i++) begin
         exp_t e;
         e.under = 1'b1; e.buf_v = 128'h0; e.cnt = (i == 0) ? 2 : 3; e.cyc = cyc + 1;
         b_sb.push_back(e);
         b_req = 1'b1;
         tick(1);
      end
      b_req = 1'b0;
      drain("drain_saturate");
      check_eq("b_count_saturated", b_cnt, 3);

      // Close mid-frame, reopen, fresh frame must not mix with the discarded words.
      a_fifo.push_back(32'hA1); a_fifo.push_back(32'hA2);
      tick(6);
      check_eq("a_pops_partial", a_pops, 10);
      a_open_bus = 1'b0;
      tick(4);
      check_eq("close_a_open", a_open, 0);
      check_eq("close_a_buffer", a_buf, 0);
      check_eq("close_a_count", a_cnt, 0);
      a_req = 1'b1;
      tick(1);
      a_req = 1'b0;
      tick(3);
      a_open_bus = 1'b1;
      tick(3);
      a_fifo.push_back(32'hB1); a_fifo.push_back(32'hB2);
      a_fifo.push_back(32'hB3); a_fifo.push_back(32'hB4);
      tick(8);
      req_a(1'b0, 128'h0000_00B4_0000_00B3_0000_00B2_0000_00B1, 0);
      drain("drain_reopen");
      check_eq("a_pops_total", a_pops, 14);

      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
